// File: rtl/instr_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue_if
//   Bundles the instruction-memory request port, the redirect input and the
//   decode-side valid/ready port of the fetch queue.
//   master : the fetch queue itself (drives imem_req/addr and inst_*)
//   slave  : the environment (memory, PC-select logic, decode)
//   Signals:
//     imem_req/imem_addr      request and its word address (fetch -> mem)
//     imem_ack/imem_rdata     completion and fetched word   (mem -> fetch)
//     redirect/redirect_pc    taken branch/jump pulse and target
//     inst_valid/inst/inst_pc head of queue                 (fetch -> decode)
//     inst_ready              decode accepts the head       (decode -> fetch)
// ----------------------------------------------------------------------------
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//   Prefetching fetch stage. Issues sequential word fetches over a req/ack
//   memory port (at most one outstanding), buffers {inst, pc} in a DEPTH-entry
//   circular FIFO and presents the head to decode with valid/ready. A redirect
//   flushes the queue and restarts fetching at the new target; a request that
//   is still in flight at that moment is drained and its data dropped.
//   Ports:
//     clk          clock, rising edge
//     rst          asynchronous reset, active low
//     bus          instr_fetch_queue_if.master (imem_*, redirect*, inst_*)
//     stat_fetched (FETCH_STATS_EN only) number of instructions popped
//     stat_flushed (FETCH_STATS_EN only) number of fetched words thrown away
//   Build option: define FETCH_STATS_EN to add the two statistics counters.
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_queue_if.master   bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           stat_fetched,
    output logic [31:0]           stat_flushed
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

    state_e               state_q, state_d;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [31:0]          addr_q, addr_d;
    logic                 req_q, req_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d, count_nxt;
    logic [DEPTH-1:0][31:0] inst_mem_q, pc_mem_q;

    logic        ack, push, pop, head_vld;
    logic [31:0] redir_pc, pc_inc;
    logic        unused_redir_lsb;

    assign unused_redir_lsb = ^bus.redirect_pc[1:0];

    // ack only means something while our request is actually out
    assign ack      = bus.imem_ack & req_q;
    assign head_vld = (count_q != '0);
    // a pop coinciding with a redirect is ignored: the FIFO is cleared anyway
    assign pop      = head_vld & bus.inst_ready & ~bus.redirect;
    assign push     = (state_q == REQ) & ack & ~bus.redirect;
    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
    assign pc_inc   = fetch_pc_q + 32'd4;

    // occupancy after this cycle's push/pop, ignoring redirect
    assign count_nxt = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        count_d    = count_nxt;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);

        unique case (state_q)
            IDLE: begin
                if (count_q < DEPTH_C) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (ack) begin
                    fetch_pc_d = pc_inc;
                    // only launch the next fetch if its word is sure to fit
                    if (count_nxt < DEPTH_C) addr_d = pc_inc;
                    else                     state_d = IDLE;
                end
            end
            DISCARD: begin
                if (ack) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            fetch_pc_d = redir_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // an unanswered request must be drained before refetching;
            // the old address stays on the bus until its ack
            if (state_q != IDLE && !ack) begin
                state_d = DISCARD;
                addr_d  = addr_q;
            end else begin
                state_d = REQ;
                addr_d  = redir_pc;
            end
        end

        req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // storage needs no reset: the head is gated by count
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= addr_q;
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = head_vld;
    assign bus.inst       = head_vld ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign bus.inst_pc    = head_vld ? pc_mem_q[rd_ptr_q]   : 32'h0;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, flushed_q, flush_inc;

    always_comb begin
        flush_inc = 32'h0;
        if (bus.redirect)
            // queued words plus a word arriving in the same cycle
            flush_inc = {{(32-CW){1'b0}}, count_q} + {31'h0, ack};
        else if (state_q == DISCARD && ack)
            flush_inc = 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= 32'h0;
            flushed_q <= 32'h0;
        end else begin
            fetched_q <= fetched_q + {31'h0, pop};
            flushed_q <= flushed_q + flush_inc;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    instr_fetch_queue_if bus();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_flushed;
`endif

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_flushed (stat_flushed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic ack, logic [31:0] rd, logic rdy, logic rq,
                                logic [31:0] ad, logic v, logic [31:0] in, logic [31:0] pc);
        vec_t r;
        r.ack = ack; r.rdata = rd; r.ready = rdy;
        r.e_req = rq; r.e_addr = ad; r.e_vld = v; r.e_inst = in; r.e_pc = pc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic rq, input logic [31:0] ad,
                       input logic v, input logic [31:0] in, input logic [31:0] pc);
        n_vec++;
        if (bus.imem_req !== rq || bus.imem_addr !== ad || bus.inst_valid !== v ||
            bus.inst !== in || bus.inst_pc !== pc) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h vld=%b inst=%h pc=%h, want req=%b addr=%h vld=%b inst=%h pc=%h",
                     nm, bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc,
                     rq, ad, v, in, pc);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rd, input logic redir,
                         input logic [31:0] rpc, input logic rdy);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rd;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.inst_ready  = rdy;
    endtask

    // check outputs of this cycle, drive this cycle's inputs, advance one clock
    task automatic step(input string nm, input logic rq, input logic [31:0] ad,
                        input logic v, input logic [31:0] in, input logic [31:0] pc,
                        input logic ack, input logic [31:0] rd, input logic redir,
                        input logic [31:0] rpc, input logic rdy);
        chk(nm, rq, ad, v, in, pc);
        drive(ack, rd, redir, rpc, rdy);
        @(negedge clk);
    endtask

    initial begin
        //            ack  rdata          rdy | req addr     vld inst           pc
        tbl[0]  = mk(0, 32'h0,        1,  0, 32'h00, 0, 32'h0,        32'h00);
        tbl[1]  = mk(1, 32'hC0DE0000, 1,  1, 32'h00, 0, 32'h0,        32'h00);
        tbl[2]  = mk(1, 32'hC0DE0004, 1,  1, 32'h04, 1, 32'hC0DE0000, 32'h00);
        tbl[3]  = mk(1, 32'hC0DE0008, 1,  1, 32'h08, 1, 32'hC0DE0004, 32'h04);
        tbl[4]  = mk(0, 32'h0,        0,  1, 32'h0C, 1, 32'hC0DE0008, 32'h08);
        tbl[5]  = mk(1, 32'hC0DE000C, 0,  1, 32'h0C, 1, 32'hC0DE0008, 32'h08);
        tbl[6]  = mk(1, 32'hC0DE0010, 0,  1, 32'h10, 1, 32'hC0DE0008, 32'h08);
        tbl[7]  = mk(1, 32'hC0DE0014, 0,  1, 32'h14, 1, 32'hC0DE0008, 32'h08);
        tbl[8]  = mk(1, 32'hDEADBEEF, 0,  0, 32'h14, 1, 32'hC0DE0008, 32'h08);
        tbl[9]  = mk(0, 32'h0,        1,  0, 32'h14, 1, 32'hC0DE0008, 32'h08);
        tbl[10] = mk(0, 32'h0,        0,  0, 32'h14, 1, 32'hC0DE000C, 32'h0C);
        tbl[11] = mk(1, 32'hC0DE0018, 0,  1, 32'h18, 1, 32'hC0DE000C, 32'h0C);
        tbl[12] = mk(0, 32'h0,        0,  0, 32'h18, 1, 32'hC0DE000C, 32'h0C);

        rst = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        chk("reset_state", 0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // zero-wait streaming, then back-pressure fills the queue
        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                 tbl[i].e_inst, tbl[i].e_pc, tbl[i].ack, tbl[i].rdata, 1'b0, 32'h0, tbl[i].ready);

        // one pop from a full queue reopens fetching; then redirect with ack+pop
        step("pop_full",   0, 32'h18, 1, 32'hC0DE000C, 32'h0C, 0, 32'h0, 0, 32'h0, 1);
        step("refill_idl", 0, 32'h18, 1, 32'hC0DE0010, 32'h10, 0, 32'h0, 0, 32'h0, 0);
        step("redir_ack",  1, 32'h1C, 1, 32'hC0DE0010, 32'h10, 1, 32'hC0DE001C, 1, 32'h202, 1);
        step("post_redir", 1, 32'h200, 0, 32'h0, 32'h0, 1, 32'hC0DE0200, 0, 32'h0, 0);
        // redirect to top of address space while a request is open
        step("head_200",   1, 32'h204, 1, 32'hC0DE0200, 32'h200, 0, 32'h0, 1, 32'hFFFFFFFC, 0);
        step("discard",    1, 32'h204, 0, 32'h0, 32'h0, 1, 32'hBAD0BAD0, 0, 32'h0, 0);
        step("fetch_top",  1, 32'hFFFFFFFC, 0, 32'h0, 32'h0, 1, 32'hC0DEFFFC, 0, 32'h0, 0);
        step("wrap_addr",  1, 32'h0, 1, 32'hC0DEFFFC, 32'hFFFFFFFC, 1, 32'hC0DE0000, 0, 32'h0, 1);
        step("wrap_head",  1, 32'h4, 1, 32'hC0DE0000, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        // async reset while waiting for an ack
        #2 rst = 1'b0;
        #1 chk("async_rst", 0, 32'h0, 0, 32'h0, 32'h0);
`ifdef FETCH_STATS_EN
        n_vec++;
        if (stat_flushed !== 32'h0 || stat_fetched !== 32'h0) begin
            n_bad++;
            $display("FAIL stat_rst: got fetched=%h flushed=%h, want 0 0", stat_fetched, stat_flushed);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 3-cycle memory; redirect lands while the fetch of 8 is outstanding
        step("s3_idle", 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_r0a",  1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_r0b",  1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_r0c",  1, 32'h0, 0, 32'h0, 32'h0, 1, 32'hC0DE0000, 0, 32'h0, 1);
        step("s3_r4a",  1, 32'h4, 1, 32'hC0DE0000, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_r4b",  1, 32'h4, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_r4c",  1, 32'h4, 0, 32'h0, 32'h0, 1, 32'hC0DE0004, 0, 32'h0, 1);
        step("s3_r8a",  1, 32'h8, 1, 32'hC0DE0004, 32'h4, 0, 32'h0, 0, 32'h0, 1);
        step("s3_redir",1, 32'h8, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h100, 1);
        step("s3_hold", 1, 32'h8, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_drop", 1, 32'h8, 0, 32'h0, 32'h0, 1, 32'hC0DE0008, 0, 32'h0, 1);
`ifdef FETCH_STATS_EN
        n_vec++;
        if (stat_flushed !== 32'd1) begin
            n_bad++;
            $display("FAIL stat_flushed: got %0d, want 1", stat_flushed);
        end
`endif
        step("s3_r100a", 1, 32'h100, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_r100b", 1, 32'h100, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        step("s3_r100c", 1, 32'h100, 0, 32'h0, 32'h0, 1, 32'hC0DE0100, 0, 32'h0, 0);
        chk("s3_head100", 1, 32'h104, 1, 32'hC0DE0100, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
